// File: rtl/queue_serial_tx.sv
// rtl/queue_serial_tx.sv - drains the word queue onto a UART-style framed serial line
// Frame: start bit, SIZE data bits LSB-first, optional even parity, STOP_BITS stop bits.
module queue_serial_tx #(
  parameter int SIZE         = 16,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_EN    = 0,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             q_empty,
  input  logic [SIZE-1:0]  q_rd_data,
  output logic             q_rd,
  output logic             tx,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (SIZE > 2) ? $clog2(SIZE) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(SIZE - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state;
  logic [SIZE-1:0] shreg;
  logic            par_bit;
  logic [BW-1:0]   baud;
  logic [IW-1:0]   bit_idx;
  logic            bit_end;

  assign bit_end = (baud == BAUD_LAST);
  assign q_rd    = (state == IDLE) && enable && !q_empty && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      words_sent <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      baud       <= '0;
      bit_idx    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (q_rd) begin
            shreg   <= q_rd_data;
            par_bit <= ^q_rd_data;
            baud    <= '0;
            bit_idx <= '0;
            tx      <= 1'b0;
            busy    <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud  <= '0;
            tx    <= shreg[0];
            state <= DATA;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud  <= '0;
            shreg <= {1'b0, shreg[SIZE-1:1]};
            if (bit_idx == IDX_LAST) begin
              bit_idx <= '0;
              if (PARITY_EN != 0) begin
                tx    <= par_bit;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              // shreg[1] becomes bit 0 on this same edge
              bit_idx <= bit_idx + IW'(1);
              tx      <= shreg[1];
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        PARITY: begin
          if (bit_end) begin
            baud  <= '0;
            tx    <= 1'b1;
            state <= STOP;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            baud <= '0;
            // bit_idx is reused to count stop bits
            if (bit_idx == STOP_LAST) begin
              bit_idx    <= '0;
              busy       <= 1'b0;
              words_sent <= words_sent + CNT_W'(1);
              state      <= IDLE;
            end else begin
              bit_idx <= bit_idx + IW'(1);
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_queue_serial_tx.sv
// tb/tb_queue_serial_tx.sv - self-checking bench for queue_serial_tx
// Three instances: defaults, parity with two stop bits, and a 2-bit word counter.
module tb_queue_serial_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [3];
  logic        en  [3];
  logic        emp [3];
  logic [15:0] rdd [3];
  logic        qrd [3];
  logic        txw [3];
  logic        bsy [3];
  logic [7:0]  ws0, ws1;
  logic [1:0]  ws2;

  logic [15:0] wq [3][32];
  int          head [3] = '{default: 0};
  int          tail [3] = '{default: 0};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      emp[i] = (head[i] == tail[i]);
      rdd[i] = wq[i][head[i] % 32];
    end
  end

  queue_serial_tx #(.SIZE(16), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_EN(0), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst[0]), .enable(en[0]), .q_empty(emp[0]), .q_rd_data(rdd[0]),
    .q_rd(qrd[0]), .tx(txw[0]), .busy(bsy[0]), .words_sent(ws0));
  queue_serial_tx #(.SIZE(16), .CLKS_PER_BIT(4), .STOP_BITS(2), .PARITY_EN(1), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst[1]), .enable(en[1]), .q_empty(emp[1]), .q_rd_data(rdd[1]),
    .q_rd(qrd[1]), .tx(txw[1]), .busy(bsy[1]), .words_sent(ws1));
  queue_serial_tx #(.SIZE(16), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_EN(0), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst[2]), .enable(en[2]), .q_empty(emp[2]), .q_rd_data(rdd[2]),
    .q_rd(qrd[2]), .tx(txw[2]), .busy(bsy[2]), .words_sent(ws2));

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // reference model: frame position counted in cycles since the pop
  logic        mact  [3] = '{default: 1'b0};
  int          mpos  [3] = '{default: 0};
  logic [15:0] mword [3];
  int          mws   [3] = '{default: 0};
  logic        armed [3] = '{default: 1'b0};
  logic        pend  [3] = '{default: 1'b0};

  int          bcnt  [3] = '{default: 0};
  logic [19:0] cap   [3] = '{default: '0};
  int          nfr   [3] = '{default: 0};
  logic [19:0] fcap  [3][64];
  int          flen  [3][64];
  int          fws   [3][64];
  int          nrd   [3] = '{default: 0};
  int          rdc   [3][64];

  function automatic int par_of(int i);  return (i == 1) ? 1 : 0; endfunction
  function automatic int stop_of(int i); return (i == 1) ? 2 : 1; endfunction
  function automatic int mask_of(int i); return (i == 2) ? 3 : 255; endfunction
  function automatic int frame_len(int i); return (1 + 16 + par_of(i) + stop_of(i)) * 4; endfunction

  function automatic logic [7:0] ws_of(int i);
    if (i == 0) return ws0;
    if (i == 1) return ws1;
    return {6'b0, ws2};
  endfunction

  function automatic logic frame_bit(int i, int pos);
    int b;
    b = pos / 4;
    if (b == 0) return 1'b0;
    if (b <= 16) return mword[i][b-1];
    if (b == 17 && par_of(i) == 1) return ^mword[i];
    return 1'b1;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(int i, logic [15:0] w);
    wq[i][tail[i] % 32] = w;
    tail[i]++;
  endtask

  task automatic step();
    cyc++;
    for (int i = 0; i < 3; i++) begin
      logic eq, etx;
      eq  = !mact[i] && en[i] && !emp[i] && !rst[i];
      etx = mact[i] ? frame_bit(i, mpos[i]) : 1'b1;
      if (armed[i]) begin
        chk($sformatf("q_rd%0d", i), 32'(qrd[i]), 32'(eq));
        chk($sformatf("tx%0d", i), 32'(txw[i]), 32'(etx));
        chk($sformatf("busy%0d", i), 32'(bsy[i]), 32'(mact[i]));
        chk($sformatf("words_sent%0d", i), 32'(ws_of(i)), 32'(mws[i] & mask_of(i)));
      end else if (rst[i]) begin
        chk($sformatf("q_rd_in_reset%0d", i), 32'(qrd[i]), 32'd0);
      end
      if (bsy[i] === 1'b1) begin
        if (bcnt[i] % 4 == 1 && bcnt[i] / 4 < 20) cap[i][bcnt[i] / 4] = txw[i];
        bcnt[i]++;
      end else if (bcnt[i] > 0) begin
        fcap[i][nfr[i] % 64] = cap[i];
        flen[i][nfr[i] % 64] = bcnt[i];
        fws[i][nfr[i] % 64]  = int'(ws_of(i));
        nfr[i]++;
        bcnt[i] = 0;
        cap[i]  = '0;
      end
      if (qrd[i] === 1'b1) begin
        rdc[i][nrd[i] % 64] = cyc;
        nrd[i]++;
      end
      pend[i] = (qrd[i] === 1'b1);
      if (rst[i]) begin
        mact[i]  = 1'b0;
        mws[i]   = 0;
        armed[i] = 1'b1;
      end else if (mact[i]) begin
        mpos[i]++;
        if (mpos[i] == frame_len(i)) begin
          mact[i] = 1'b0;
          mws[i]++;
        end
      end else if (eq) begin
        mact[i]  = 1'b1;
        mpos[i]  = 0;
        mword[i] = rdd[i];
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) if (pend[i]) head[i]++;
  endtask

  task automatic wait_frames(int i, int target, int budget);
    int n = 0;
    while (nfr[i] < target && n < budget) begin tick(); n++; end
    chk($sformatf("frames_done_timeout%0d", i), 32'(nfr[i] >= target), 32'd1);
  endtask

  task automatic wait_rd(int i, int target, int budget);
    int n = 0;
    while (nrd[i] < target && n < budget) begin tick(); n++; end
    chk($sformatf("pop_timeout%0d", i), 32'(nrd[i] >= target), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bf, br;
    logic [15:0] w3 [3];
    logic [15:0] w5 [5];
    int exp_ws [5];
    exp_ws = '{1, 2, 3, 0, 1};
    w3 = '{16'h0001, 16'hFFFF, 16'h8000};
    for (int i = 0; i < 3; i++) rst[i] = 1'b1;
    en[0] = 1'b1; en[1] = 1'b0; en[2] = 1'b0;
    push(0, 16'hA5C3);
    push(1, 16'h0001);
    push(1, 16'h0003);
    tick();
    tick();
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    #1;
    chk("first_pop_after_reset", 32'(qrd[0]), 32'd1);
    chk("reset_tx", 32'(txw[0]), 32'd1);
    chk("reset_busy", 32'(bsy[0]), 32'd0);
    chk("reset_words_sent", 32'(ws0), 32'd0);

    // single word, defaults
    wait_frames(0, 1, 200);
    chk("a5c3_len", 32'(flen[0][0]), 32'd72);
    chk("a5c3_bits", 32'(fcap[0][0][17:0]), 32'({1'b1, 16'hA5C3, 1'b0}));
    chk("a5c3_words_sent", 32'(ws0), 32'd1);
    chk("a5c3_pops", 32'(nrd[0]), 32'd1);

    // three back-to-back words
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    bf = nfr[0]; br = nrd[0];
    for (int k = 0; k < 3; k++) push(0, w3[k]);
    wait_frames(0, bf + 3, 400);
    repeat (20) tick();
    chk("three_pops", 32'(nrd[0] - br), 32'd3);
    chk("gap_1_2", 32'(rdc[0][(br + 1) % 64] - rdc[0][br % 64]), 32'd73);
    chk("gap_2_3", 32'(rdc[0][(br + 2) % 64] - rdc[0][(br + 1) % 64]), 32'd73);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("decode%0d", k), 32'(fcap[0][(bf + k) % 64][16:1]), 32'(w3[k]));
      chk($sformatf("len%0d", k), 32'(flen[0][(bf + k) % 64]), 32'd72);
    end
    chk("three_words_sent", 32'(ws0), 32'd3);

    // enable dropped mid-frame
    bf = nfr[0]; br = nrd[0];
    for (int k = 0; k < 3; k++) push(0, 16'($urandom));
    wait_rd(0, br + 1, 20);
    repeat (29) tick();
    en[0] = 1'b0;
    wait_frames(0, bf + 1, 100);
    chk("drop_len", 32'(flen[0][bf % 64]), 32'd72);
    repeat (10) tick();
    chk("drop_no_pop", 32'(nrd[0] - br), 32'd1);
    chk("drop_idle_tx", 32'(txw[0]), 32'd1);
    chk("drop_idle_busy", 32'(bsy[0]), 32'd0);
    en[0] = 1'b1;
    #1;
    chk("reenable_pop", 32'(qrd[0]), 32'd1);
    wait_frames(0, bf + 3, 300);
    chk("drop_total_pops", 32'(nrd[0] - br), 32'd3);

    // parity and two stop bits
    en[1] = 1'b1;
    wait_frames(1, 2, 300);
    chk("par_len0", 32'(flen[1][0]), 32'd80);
    chk("par_len1", 32'(flen[1][1]), 32'd80);
    chk("par_bit_0001", 32'(fcap[1][0][17]), 32'd1);
    chk("par_bit_0003", 32'(fcap[1][1][17]), 32'd0);
    chk("par_data_0001", 32'(fcap[1][0][16:1]), 32'h0001);
    chk("par_stop_bits", 32'(fcap[1][0][19:18]), 32'd3);

    // reset mid-frame, then counter wrap
    en[2] = 1'b1;
    push(2, 16'($urandom));
    wait_rd(2, nrd[2] + 1, 20);
    repeat (39) tick();
    rst[2] = 1'b1;
    tick();
    chk("midreset_tx", 32'(txw[2]), 32'd1);
    chk("midreset_busy", 32'(bsy[2]), 32'd0);
    chk("midreset_words_sent", 32'(ws2), 32'd0);
    rst[2] = 1'b0;
    tick();
    bf = nfr[2];
    for (int k = 0; k < 5; k++) begin
      w5[k] = 16'($urandom);
      push(2, w5[k]);
    end
    wait_frames(2, bf + 5, 500);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("wrap_ws%0d", k), 32'(fws[2][(bf + k) % 64]), 32'(exp_ws[k]));
      chk($sformatf("wrap_data%0d", k), 32'(fcap[2][(bf + k) % 64][16:1]), 32'(w5[k]));
    end

    // random pushes, enable toggles and occasional resets
    for (int n = 0; n < 3000; n++) begin
      if (rst[0]) rst[0] = 1'b0;
      else rst[0] = ($urandom_range(399) == 0);
      if ($urandom_range(39) == 0) en[0] = ~en[0];
      if ($urandom_range(59) == 0 && (tail[0] - head[0]) < 20) push(0, 16'($urandom));
      tick();
    end
    rst[0] = 1'b0;
    en[0] = 1'b1;
    begin
      int n = 0;
      while ((head[0] != tail[0] || bsy[0] === 1'b1) && n < 2000) begin tick(); n++; end
      chk("random_drain", 32'(head[0] == tail[0]), 32'd1);
    end
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/queue_serial_tx.md
Name: queue_serial_tx

Overview:
- Drain side of the 16-bit word queue.
- Pops words from the queue whenever it is non-empty and enabled, and shifts each word out on a single-wire, UART-style framed serial line: start bit, data LSB-first, optional even parity, stop bit(s).
- Sits between the queue's read port and the chip's serial output pin.

Parameters:
- SIZE, 16: data word width; must match the queue word width.
- CLKS_PER_BIT, 4: clk cycles per serial bit; must be at least 2.
- STOP_BITS, 1: number of stop bits; 1 or 2.
- PARITY_EN, 0: 1 inserts an even-parity bit after the data bits.
- CNT_W, 8: width of the words_sent counter.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, synchronous, active-high.
- enable, input, 1: permits new words to be popped.
- q_empty, input, 1: queue empty flag.
- q_rd_data, input, SIZE: queue head word; show-ahead, valid whenever q_empty=0.
- q_rd, output, 1: pop strobe to the queue; combinational.
- tx, output, 1: serial line; registered; idles high.
- busy, output, 1: frame in progress; registered.
- words_sent, output, CNT_W: count of completed frames; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=1 at a posedge):
  - Next cycle: state=IDLE, tx=1, busy=0, words_sent=0, shift register and counters cleared.
  - q_rd=0 throughout reset regardless of q_empty.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - q_rd = enable & ~q_empty & ~rst, asserted for exactly one cycle.
  - On that edge: q_rd_data is latched into the shift register, state becomes START, busy becomes 1, tx becomes 0.
  - The queue advances on the same edge.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - Shift register bit 0 drives tx for CLKS_PER_BIT cycles, then the register shifts right.
  - After SIZE bits: go to PARITY if PARITY_EN=1, else STOP.
- PARITY: tx = XOR of the latched word for CLKS_PER_BIT cycles (even parity), then STOP.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the final cycle's edge: words_sent increments, busy becomes 0, state becomes IDLE.
- Bit timing:
  - A baud counter counts 0..CLKS_PER_BIT-1; it reloads on every bit boundary and on entry to START.
  - A bit index counter runs 0..SIZE-1.
- Frame length: (1 + SIZE + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles of busy=1.
  - Defaults: 72 cycles.
- Back-to-back frames:
  - Exactly one IDLE cycle (tx=1, busy=0) between frames; the pop occurs in that cycle.
  - Consecutive q_rd pulses are therefore 73 cycles apart at defaults.
- Flags while busy:
  - enable deasserted mid-frame: the current frame completes unchanged; no pop in IDLE until enable returns.
  - q_empty is ignored outside IDLE; q_rd is never asserted outside IDLE.
  - q_rd_data changes after the pop do not affect the frame in flight.
- Reset mid-frame:
  - The frame is abandoned and the popped word is lost; no recovery.
  - Next cycle: tx=1, busy=0, words_sent=0.
- words_sent wraps from 2^CNT_W-1 to 0 with no flag.
- The shift register holds only the current word; there is no internal buffering beyond it.

Test Plan:
- Reset behaviour:
  - Stimulus: assert rst for 2 cycles with q_empty=0, enable=1.
  - Required: q_rd=0 in both cycles; after release tx=1, busy=0, words_sent=0; the first q_rd occurs the cycle after rst deasserts.
- Single word 0xA5C3, defaults:
  - Required: one q_rd pulse.
  - tx sequence, each level held 4 cycles: 0, then 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, then 1.
  - busy high for 72 cycles; words_sent=1.
- Three queued words 0x0001, 0xFFFF, 0x8000:
  - Required: exactly 3 q_rd pulses, 73 cycles apart; frames decode to the same values in order; words_sent=3; no 4th pulse once q_empty=1.
- PARITY_EN=1, STOP_BITS=2:
  - 0x0001 gives parity bit 1; 0x0003 gives parity bit 0.
  - Stop high for 8 cycles; frame length 80 cycles.
- Enable dropped mid-frame:
  - Stimulus: deassert enable at cycle 30 of a frame with 2 words still queued.
  - Required: the frame completes to 72 cycles, then tx=1 and no q_rd.
  - Re-assert enable 10 cycles later: q_rd follows in the same cycle and a new frame starts.
- Reset during DATA, plus counter wrap:
  - rst at cycle 40 of a frame: next cycle tx=1, busy=0, words_sent=0.
  - With CNT_W=2: five frames give words_sent = 1, 2, 3, 0, 1.
